rc4_prga_xor_engine: RTL and testbench

//  RC4 keystream generator (PRGA) fused with an XOR stage; parametrised successor of the fixed 32-byte decrypt block.

---
 rtl/rc4_pkg.sv | 33 +++
 rtl/rc4_char_filter.sv | 20 ++
 rtl/rc4_prga_xor_engine.sv | 203 ++++++++++++++++++++
 tb/tb_rc4_prga_xor_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Package : rc4_pkg
// Brief   : Shared RC4 types and filter defaults (PRGA, KSA, key search)
// Rev     : 1.0
// ============================================================================
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int c_CHAR_LO  = 97;
  localparam int c_CHAR_HI  = 122;
  localparam int c_CHAR_EXT = 32;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INC_I = 4'd1,
    ST_RD_SI = 4'd2,
    ST_WT_SI = 4'd3,
    ST_UPD_J = 4'd4,
    ST_RD_SJ = 4'd5,
    ST_WT_SJ = 4'd6,
    ST_WR_SI = 4'd7,
    ST_WR_SJ = 4'd8,
    ST_RD_F  = 4'd9,
    ST_WT_F  = 4'd10,
    ST_XOR   = 4'd11,
    ST_CHK   = 4'd12,
    ST_DONE  = 4'd13
  } prga_state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_char_filter.sv
`default_nettype none
// ============================================================================
// Module  : rc4_char_filter
// Brief   : Accepts a byte inside [lo, hi] or equal to one extra character
// Rev     : 1.0
// ============================================================================
module rc4_char_filter
  import rc4_pkg::*;
(
  input  byte_t i_byte,
  input  byte_t i_lo,
  input  byte_t i_hi,
  input  byte_t i_ext,
  output logic  o_accept
);

  assign o_accept = ((i_byte >= i_lo) && (i_byte <= i_hi)) || (i_byte == i_ext);

endmodule
`default_nettype wire

// File: rtl/rc4_prga_xor_engine.sv
`default_nettype none
// ============================================================================
// Module  : rc4_prga_xor_engine
// Brief   : RC4 keystream generator fused with ciphertext XOR and char filter
// Rev     : 1.0
// ============================================================================
module rc4_prga_xor_engine
  import rc4_pkg::*;
#(
  parameter int MSG_LEN  = 32,
  parameter int MSG_AW   = 5,
  parameter int RD_LAT   = 1,
  parameter int CHAR_LO  = c_CHAR_LO,
  parameter int CHAR_HI  = c_CHAR_HI,
  parameter int CHAR_EXT = c_CHAR_EXT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              check_en,
  output logic              busy,
  output logic              done,
  output logic              invalid,
  output logic [MSG_AW-1:0] fail_index,
  output logic [MSG_AW:0]   bytes_out,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wren
);

  localparam logic [MSG_AW-1:0] c_K_LAST    = MSG_AW'(MSG_LEN - 1);
  localparam logic [1:0]        c_WAIT_INIT = 2'(RD_LAT - 1);

  prga_state_t       r_state;
  prga_state_t       w_state_nxt;
  byte_t             r_i, r_j, r_si, r_sj, r_f;
  logic [MSG_AW-1:0] r_k;
  logic [1:0]        r_wait;
  logic              r_check_en;
  logic              r_invalid;
  logic [MSG_AW-1:0] r_fail_index;
  logic [MSG_AW:0]   r_bytes_out;
  byte_t             r_s_address, r_s_data, r_d_data;
  logic [MSG_AW-1:0] r_rom_address, r_d_address;
  logic              w_accept;
  logic              w_wait_zero;
  logic              w_busy, w_done, w_s_wren, w_d_wren;

  assign w_wait_zero = (r_wait == 2'd0);

  rc4_char_filter u_filter (
    .i_byte   (r_f),
    .i_lo     (byte_t'(CHAR_LO)),
    .i_hi     (byte_t'(CHAR_HI)),
    .i_ext    (byte_t'(CHAR_EXT)),
    .o_accept (w_accept)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != ST_IDLE);
    w_done      = (r_state == ST_DONE);
    w_s_wren    = (r_state == ST_WR_SI) || (r_state == ST_WR_SJ);
    w_d_wren    = (r_state == ST_XOR);
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_INC_I;
      ST_INC_I: w_state_nxt = ST_RD_SI;
      ST_RD_SI: w_state_nxt = ST_WT_SI;
      ST_WT_SI: if (w_wait_zero) w_state_nxt = ST_UPD_J;
      ST_UPD_J: w_state_nxt = ST_RD_SJ;
      ST_RD_SJ: w_state_nxt = ST_WT_SJ;
      ST_WT_SJ: if (w_wait_zero) w_state_nxt = ST_WR_SI;
      ST_WR_SI: w_state_nxt = ST_WR_SJ;
      ST_WR_SJ: w_state_nxt = ST_RD_F;
      ST_RD_F:  w_state_nxt = ST_WT_F;
      ST_WT_F:  if (w_wait_zero) w_state_nxt = ST_XOR;
      ST_XOR:   w_state_nxt = ST_CHK;
      ST_CHK: begin
        if ((!w_accept && r_check_en) || (r_k == c_K_LAST)) w_state_nxt = ST_DONE;
        else                                                w_state_nxt = ST_INC_I;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Write address/data are staged one state ahead so the decoded wren
  // always sees a stable registered pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_si          <= '0;
      r_sj          <= '0;
      r_f           <= '0;
      r_wait        <= '0;
      r_check_en    <= 1'b0;
      r_invalid     <= 1'b0;
      r_fail_index  <= '0;
      r_bytes_out   <= '0;
      r_s_address   <= '0;
      r_s_data      <= '0;
      r_rom_address <= '0;
      r_d_address   <= '0;
      r_d_data      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_check_en   <= check_en;
            r_invalid    <= 1'b0;
            r_fail_index <= '0;
            r_bytes_out  <= '0;
          end
        end
        ST_INC_I: begin
          r_i           <= r_i + 8'd1;
          r_s_address   <= r_i + 8'd1;
          r_rom_address <= r_k;
        end
        ST_RD_SI, ST_RD_SJ, ST_RD_F: r_wait <= c_WAIT_INIT;
        ST_WT_SI: if (!w_wait_zero) r_wait <= r_wait - 2'd1;
        ST_UPD_J: begin
          r_si        <= s_q;
          r_j         <= r_j + s_q;
          r_s_address <= r_j + s_q;
        end
        ST_WT_SJ: begin
          if (!w_wait_zero) begin
            r_wait <= r_wait - 2'd1;
          end else begin
            r_sj        <= s_q;
            r_s_address <= r_i;
            r_s_data    <= s_q;
          end
        end
        ST_WR_SI: begin
          r_s_address <= r_j;
          r_s_data    <= r_si;
        end
        ST_WR_SJ: begin
          r_s_address <= r_si + r_sj;
          r_s_data    <= '0;
        end
        ST_WT_F: begin
          if (!w_wait_zero) begin
            r_wait <= r_wait - 2'd1;
          end else begin
            r_f         <= s_q ^ rom_q;
            r_d_address <= r_k;
            r_d_data    <= s_q ^ rom_q;
          end
        end
        ST_XOR: r_bytes_out <= {1'b0, r_k} + (MSG_AW+1)'(1);
        ST_CHK: begin
          if (!w_accept && r_check_en) begin
            r_invalid    <= 1'b1;
            r_fail_index <= r_k;
          end else if (r_k != c_K_LAST) begin
            r_k <= r_k + MSG_AW'(1);
          end
          if (w_state_nxt == ST_DONE) begin
            r_s_address <= '0;
            r_s_data    <= '0;
            r_d_address <= '0;
            r_d_data    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign s_wren      = w_s_wren;
  assign d_wren      = w_d_wren;
  assign invalid     = r_invalid;
  assign fail_index  = r_fail_index;
  assign bytes_out   = r_bytes_out;
  assign s_address   = r_s_address;
  assign s_data      = r_s_data;
  assign rom_address = r_rom_address;
  assign d_address   = r_d_address;
  assign d_data      = r_d_data;

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_xor_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_rc4_prga_xor_engine
// Brief   : Bench for two engine instances (RD_LAT 1 and 3) against an RC4 model
// Rev     : 1.0
// ============================================================================
module tb_rc4_prga_xor_engine;

  localparam int c_LEN = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, check_en;
  logic       start [2];
  logic       busy [2], done [2], invalid [2], s_wren [2], d_wren [2];
  logic [3:0] fail_index [2], rom_address [2], d_address [2];
  logic [4:0] bytes_out [2];
  logic [7:0] s_address [2], s_data [2], s_q [2], rom_q [2], d_data [2];

  rc4_prga_xor_engine #(.MSG_LEN(c_LEN), .MSG_AW(4), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start[0]), .check_en(check_en),
    .busy(busy[0]), .done(done[0]), .invalid(invalid[0]), .fail_index(fail_index[0]),
    .bytes_out(bytes_out[0]), .s_address(s_address[0]), .s_data(s_data[0]),
    .s_wren(s_wren[0]), .s_q(s_q[0]), .rom_address(rom_address[0]), .rom_q(rom_q[0]),
    .d_address(d_address[0]), .d_data(d_data[0]), .d_wren(d_wren[0])
  );

  rc4_prga_xor_engine #(.MSG_LEN(c_LEN), .MSG_AW(4), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start[1]), .check_en(check_en),
    .busy(busy[1]), .done(done[1]), .invalid(invalid[1]), .fail_index(fail_index[1]),
    .bytes_out(bytes_out[1]), .s_address(s_address[1]), .s_data(s_data[1]),
    .s_wren(s_wren[1]), .s_q(s_q[1]), .rom_address(rom_address[1]), .rom_q(rom_q[1]),
    .d_address(d_address[1]), .d_data(d_data[1]), .d_wren(d_wren[1])
  );

  // Memories with a read pipeline of RD_LAT stages on registered addresses
  logic [7:0] smem [2][256];
  logic [7:0] rom [2][16];
  logic [7:0] dmem [2][16];
  logic [7:0] s_pipe [2][4];
  logic [7:0] r_pipe [2][4];
  int         dwrites [2];
  logic       load_req [2];
  logic [7:0] init_s [256];
  logic [7:0] init_rom [16];

  assign s_q[0]   = s_pipe[0][0];
  assign rom_q[0] = r_pipe[0][0];
  assign s_q[1]   = s_pipe[1][2];
  assign rom_q[1] = r_pipe[1][2];

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (load_req[n]) begin
        for (int a = 0; a < 256; a++) smem[n][a] <= init_s[a];
        for (int a = 0; a < 16; a++) begin
          rom[n][a]  <= init_rom[a];
          dmem[n][a] <= 8'h00;
        end
        dwrites[n] <= 0;
      end else begin
        if (s_wren[n]) smem[n][s_address[n]] <= s_data[n];
        if (d_wren[n]) begin
          dmem[n][d_address[n]] <= d_data[n];
          dwrites[n] <= dwrites[n] + 1;
        end
      end
      s_pipe[n][0] <= smem[n][s_address[n]];
      r_pipe[n][0] <= rom[n][rom_address[n]];
      for (int p = 1; p < 4; p++) begin
        s_pipe[n][p] <= s_pipe[n][p-1];
        r_pipe[n][p] <= r_pipe[n][p-1];
      end
    end
  end

  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: textbook RC4 PRGA over a copy of init_s, XOR with init_rom
  logic [7:0] m_s [256];
  logic [7:0] m_d [16];
  int         m_cnt, m_fidx;
  bit         m_inv;

  task automatic model_run(input bit ce);
    int i, j;
    logic [7:0] t, ks, b;
    for (int a = 0; a < 256; a++) m_s[a] = init_s[a];
    i = 0; j = 0; m_cnt = 0; m_inv = 0; m_fidx = 0;
    for (int k = 0; k < c_LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      ks = m_s[(m_s[i] + m_s[j]) % 256];
      b = init_rom[k] ^ ks;
      m_d[k] = b;
      m_cnt++;
      if (ce && !(b == 8'h20 || (b >= 8'h61 && b <= 8'h7a))) begin
        m_inv = 1; m_fidx = k;
        break;
      end
    end
  endtask

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] t;
    int j;
    key[0] = 8'h4b; key[1] = 8'h65; key[2] = 8'h79;
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + init_s[a] + key[a % 3]) % 256;
      t = init_s[a]; init_s[a] = init_s[j]; init_s[j] = t;
    end
  endtask

  // ROM = plaintext ^ keystream of the current init_s
  task automatic encrypt(input logic [8*c_LEN-1:0] pt);
    for (int k = 0; k < 16; k++) init_rom[k] = 8'h00;
    model_run(1'b0);
    for (int k = 0; k < c_LEN; k++) init_rom[k] = pt[8*(c_LEN-1-k) +: 8] ^ m_d[k];
  endtask

  task automatic load(input int n);
    @(negedge clk); load_req[n] = 1'b1;
    @(negedge clk); load_req[n] = 1'b0;
  endtask

  task automatic run(input int n, input bit ce, input bit poke, output int cyc);
    int guard, extra;
    @(negedge clk); check_en = ce; start[n] = 1'b1; cyc = 1;
    @(posedge clk); #1; start[n] = 1'b0; cyc = 2;
    chk($sformatf("busy_after_start%0d", n), busy[n], 1);
    guard = 0;
    while (!done[n] && guard < 400) begin
      start[n] = (poke && guard == 7);
      @(posedge clk); #1; cyc++; guard++;
    end
    start[n] = 1'b0;
    chk($sformatf("done_seen%0d", n), done[n], 1);
    start[n] = poke;
    @(posedge clk); #1; start[n] = 1'b0;
    extra = 0;
    repeat (12) begin
      if (done[n] || busy[n]) extra++;
      @(posedge clk); #1;
    end
    chk($sformatf("idle_after_done%0d", n), extra, 0);
  endtask

  task automatic verify(input int n, input string tag, input int cyc);
    int bad;
    for (int k = 0; k < m_cnt; k++) chk($sformatf("%s_d%0d", tag, k), dmem[n][k], m_d[k]);
    chk({tag, "_nwrites"}, dwrites[n], m_cnt);
    chk({tag, "_bytes_out"}, bytes_out[n], m_cnt);
    chk({tag, "_invalid"}, invalid[n], m_inv);
    chk({tag, "_fail_index"}, fail_index[n], m_inv ? m_fidx : 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (smem[n][a] !== m_s[a]) bad++;
    chk({tag, "_s_array"}, bad, 0);
    if (!m_inv) chk({tag, "_latency"}, cyc, c_LEN * (9 + 3 * (n == 0 ? 1 : 3)) + 2);
  endtask

  task automatic chk_zero(input int n, input string tag);
    chk({tag, "_ctrl"}, {busy[n], done[n], invalid[n], s_wren[n], d_wren[n],
                         fail_index[n], bytes_out[n]}, 0);
    chk({tag, "_addr"}, {s_address[n], s_data[n], rom_address[n], d_address[n], d_data[n]}, 0);
  endtask

  task automatic shuffle_s();
    logic [7:0] t;
    int b;
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
    for (int a = 255; a > 0; a--) begin
      b = $urandom_range(0, a);
      t = init_s[a]; init_s[a] = init_s[b]; init_s[b] = t;
    end
  endtask

  initial begin
    logic [8*c_LEN-1:0] pt;
    logic [8*c_LEN-1:0] kat_ct;
    int cyc, guard, n;
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; check_en = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    load_req[0] = 1'b0; load_req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk); reset = 1'b0;

    // Known-answer: RC4("Key") over "Plaintext"
    ksa_key();
    kat_ct = 72'hBBF316E8D940AF0AD3;
    for (int k = 0; k < 16; k++) init_rom[k] = 8'h00;
    for (int k = 0; k < c_LEN; k++) init_rom[k] = kat_ct[8*(c_LEN-1-k) +: 8];
    pt = "Plaintext";
    for (int i = 0; i < 2; i++) begin
      load(i);
      run(i, 1'b0, 1'b0, cyc);
      model_run(1'b0);
      verify(i, $sformatf("kat%0d", i), cyc);
      for (int k = 0; k < c_LEN; k++)
        chk($sformatf("kat%0d_text%0d", i, k), dmem[i][k], pt[8*(c_LEN-1-k) +: 8]);
    end

    // Same vector with filter on: 'P' rejected at k=0
    load(0);
    run(0, 1'b1, 1'b0, cyc);
    model_run(1'b1);
    verify(0, "kat_chk", cyc);
    chk("kat_chk_invalid", invalid[0], 1);
    chk("kat_chk_bytes", bytes_out[0], 1);

    // Identity S, fully accepted text; extra start pulses while busy and in DONE
    for (int a = 0; a < 256; a++) init_s[a] = 8'(a);
    encrypt("abc zyx q");
    for (int i = 0; i < 2; i++) begin
      load(i);
      run(i, 1'b1, 1'b1, cyc);
      model_run(1'b1);
      verify(i, $sformatf("ident%0d", i), cyc);
    end

    // Reset in the middle of byte k=5, then a clean rerun
    shuffle_s();
    for (int k = 0; k < 16; k++) init_rom[k] = 8'($urandom_range(0, 255));
    load(0);
    @(negedge clk); check_en = 1'b0; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    guard = 0;
    while (dwrites[0] < 5 && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    chk("midrst_reached_k5", dwrites[0], 5);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk_zero(0, "midrst");
    @(negedge clk); reset = 1'b0;
    load(0);
    run(0, 1'b0, 1'b0, cyc);
    model_run(1'b0);
    verify(0, "midrst_rerun", cyc);

    // Randomised permutations and texts, occasional out-of-range bytes
    for (int it = 0; it < 8; it++) begin
      int r;
      bit ce;
      n = it % 2;
      ce = 1'($urandom_range(0, 1));
      shuffle_s();
      for (int k = 0; k < c_LEN; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      pt[8*(c_LEN-1-k) +: 8] = 8'($urandom_range(0, 255));
        else if (r == 1) pt[8*(c_LEN-1-k) +: 8] = 8'h20;
        else             pt[8*(c_LEN-1-k) +: 8] = 8'(8'h61 + $urandom_range(0, 25));
      end
      encrypt(pt);
      load(n);
      run(n, ce, 1'(it % 3 == 0), cyc);
      model_run(ce);
      verify(n, $sformatf("rand%0d", it), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
